// File: rtl/fp_result_buffer_if.sv
// fp_result_buffer_if
//   Data path between the floating-point adder, the result buffer and its
//   consumer.
//   master : testbench / system side. Drives the adder pair and the consumer ready.
//   slave  : fp_result_buffer side. Receives the pair and presents the head entry.
// Signals:
//   in_result[31:0], in_state[1:0], in_vld : adder result, status and res_vld
//   out_result[31:0], out_state[1:0]       : head entry (zero while out_vld is 0)
//   out_vld, out_rdy                       : consumer valid/ready handshake
interface fp_result_buffer_if;
  logic [31:0] in_result;
  logic [1:0]  in_state;
  logic        in_vld;
  logic [31:0] out_result;
  logic [1:0]  out_state;
  logic        out_vld;
  logic        out_rdy;

  modport master (
    output in_result, in_state, in_vld, out_rdy,
    input  out_result, out_state, out_vld
  );

  modport slave (
    input  in_result, in_state, in_vld, out_rdy,
    output out_result, out_state, out_vld
  );
endinterface

// File: rtl/fp_result_buffer.sv
// fp_result_buffer
//   Elastic show-ahead FIFO behind the pipelined FP adder. The adder cannot be
//   stalled, so a pair arriving while the FIFO is full and not popping is
//   dropped and recorded in overflow / drop_cnt.
//   Optional feature macro: FP_RESULT_STATS_EN builds the nan/inf/nul counters.
//   Without the macro those three ports are tied to 0.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   bus       : fp_result_buffer_if.slave (adder input, consumer output)
//   count     : occupancy 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, set when any pair was dropped
//   drop_cnt  : saturating count of dropped pairs
//   nan_cnt, inf_cnt, nul_cnt : saturating counts of accepted pairs per status
module fp_result_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_result_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       nan_cnt,
  output logic [CNT_W-1:0]       inf_cnt,
  output logic [CNT_W-1:0]       nul_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  logic [33:0]   head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign pop  = bus.out_vld && bus.out_rdy;
  assign push = bus.in_vld && (!full || pop);
  assign drop = bus.in_vld && full && !pop;

  assign head           = mem[rd_ptr];
  assign bus.out_vld    = !empty;
  assign bus.out_result = bus.out_vld ? head[31:0]  : 32'd0;
  assign bus.out_state  = bus.out_vld ? head[33:32] : 2'd0;

  // Storage carries no reset; a pair offered during reset is not written.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= {bus.in_state, bus.in_result};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FP_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      nan_cnt <= '0;
      inf_cnt <= '0;
      nul_cnt <= '0;
    end else if (push) begin
      case (bus.in_state)
        2'b01:   if (nan_cnt != '1) nan_cnt <= nan_cnt + CNT_W'(1);
        2'b10:   if (inf_cnt != '1) inf_cnt <= inf_cnt + CNT_W'(1);
        2'b11:   if (nul_cnt != '1) nul_cnt <= nul_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end
`else
  assign nan_cnt = '0;
  assign inf_cnt = '0;
  assign nul_cnt = '0;
`endif
endmodule

// File: tb/tb_fp_result_buffer.sv
// tb_fp_result_buffer
//   Self-checking bench for fp_result_buffer. A queue-based FIFO model tracks
//   accepted pairs, drops and per-status counts. Honors FP_RESULT_STATS_EN.
module tb_fp_result_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FP_RESULT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  fp_result_buffer_if bus ();
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] nan_cnt;
  logic [CNT_W-1:0] inf_cnt;
  logic [CNT_W-1:0] nul_cnt;

  fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .nan_cnt  (nan_cnt),
    .inf_cnt  (inf_cnt),
    .nul_cnt  (nul_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents of the FIFO in order, plus event tallies.
  logic [33:0]      q[$];
  logic [CNT_W-1:0] m_drop = '0;
  logic [CNT_W-1:0] m_nan  = '0;
  logic [CNT_W-1:0] m_inf  = '0;
  logic [CNT_W-1:0] m_nul  = '0;
  logic             m_ovf  = 1'b0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] exp_stat(input logic [CNT_W-1:0] v);
    return STATS ? v : '0;
  endfunction

  task automatic drive(input logic vld, input logic [31:0] res,
                       input logic [1:0] st, input logic rdy);
    bus.in_vld    = vld;
    bus.in_result = res;
    bus.in_state  = st;
    bus.out_rdy   = rdy;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit do_pop;
    bit do_push;
    if (!rst) begin
      q.delete();
      m_drop = '0; m_nan = '0; m_inf = '0; m_nul = '0; m_ovf = 1'b0;
    end else begin
      do_pop  = (q.size() != 0) && bus.out_rdy;
      do_push = bus.in_vld && ((q.size() < DEPTH) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back({bus.in_state, bus.in_result});
        if (bus.in_state == 2'b01) m_nan = sat_inc(m_nan);
        if (bus.in_state == 2'b10) m_inf = sat_inc(m_inf);
        if (bus.in_state == 2'b11) m_nul = sat_inc(m_nul);
      end else if (bus.in_vld) begin
        m_drop = sat_inc(m_drop);
        m_ovf  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({count, full, empty, overflow} !== {CW'(0), 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_status: got count=%0d full=%b empty=%b ovf=%b want 0 0 1 0",
               count, full, empty, overflow);
    end
    n_tests++;
    if ({bus.out_vld, bus.out_state, bus.out_result} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_head: got vld=%b st=%b res=%h want all zero",
               bus.out_vld, bus.out_state, bus.out_result);
    end
    n_tests++;
    if ({drop_cnt, nan_cnt, inf_cnt, nul_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got drop=%0d nan=%0d inf=%0d nul=%0d want 0",
               drop_cnt, nan_cnt, inf_cnt, nul_cnt);
    end
  endtask

  task automatic test_first_push();
    drive(1'b1, 32'h3F800000, 2'b00, 1'b0);
    #1;
    n_tests++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL first_push_same_cycle: got out_vld=%b want 0", bus.out_vld);
    end
    tick();
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    n_tests++;
    if ({bus.out_vld, bus.out_state, bus.out_result} !== {1'b1, 2'b00, 32'h3F800000}) begin
      n_fail++;
      $display("FAIL first_push_head: got vld=%b st=%b res=%h want 1 00 3f800000",
               bus.out_vld, bus.out_state, bus.out_result);
    end
    n_tests++;
    if (count !== CW'(1)) begin
      n_fail++;
      $display("FAIL first_push_count: got %0d want 1", count);
    end
    drive(1'b0, 32'd0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [33:0] sent [10];
    for (int i = 0; i < 10; i++) begin
      sent[i] = {2'($urandom), 32'($urandom)};
      drive(1'b1, sent[i][31:0], sent[i][33:32], 1'b0);
      tick();
      if (i == 6 || i == 7) begin
        n_tests++;
        if (full !== (i == 7)) begin
          n_fail++;
          $display("FAIL overflow_full_after_%0d: got %b want %b", i + 1, full, (i == 7));
        end
      end
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    n_tests++;
    if ({drop_cnt, overflow, count} !== {CNT_W'(2), 1'b1, CW'(DEPTH)}) begin
      n_fail++;
      $display("FAIL overflow_drops: got drop=%0d ovf=%b count=%0d want 2 1 8",
               drop_cnt, overflow, count);
    end
    drive(1'b0, 32'd0, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({bus.out_vld, bus.out_state, bus.out_result} !== {1'b1, sent[i]}) begin
        n_fail++;
        $display("FAIL overflow_drain_%0d: got vld=%b %h want 1 %h",
                 i, bus.out_vld, {bus.out_state, bus.out_result}, sent[i]);
      end
      tick();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    n_tests++;
    if ({empty, bus.out_vld} !== 2'b10) begin
      n_fail++;
      $display("FAIL overflow_drained_empty: got empty=%b vld=%b want 1 0", empty, bus.out_vld);
    end
  endtask

  task automatic test_full_passthrough();
    logic [CNT_W-1:0] drops_before;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, $urandom, 2'($urandom), 1'b0);
      tick();
    end
    drops_before = m_drop;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, 2'($urandom), 1'b1);
      #1;
      n_tests++;
      if ({bus.out_vld, bus.out_state, bus.out_result} !== {1'b1, q[0]}) begin
        n_fail++;
        $display("FAIL passthrough_head_%0d: got %h want %h",
                 i, {bus.out_state, bus.out_result}, q[0]);
      end
      tick();
      n_tests++;
      if ({count, drop_cnt} !== {CW'(DEPTH), drops_before}) begin
        n_fail++;
        $display("FAIL passthrough_count_%0d: got count=%0d drop=%0d want 8 %0d",
                 i, count, drop_cnt, drops_before);
      end
    end
    drive(1'b0, 32'd0, 2'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if ({bus.out_vld, bus.out_state, bus.out_result} !== {1'b1, q[0]}) begin
        n_fail++;
        $display("FAIL passthrough_drain_%0d: got %h want %h",
                 i, {bus.out_state, bus.out_result}, q[0]);
      end
      tick();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic test_stats();
    logic [33:0] vec [4];
    vec = '{{2'b01, 32'h7FC00000}, {2'b10, 32'h7F800000},
            {2'b11, 32'h80000000}, {2'b00, 32'h40000000}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vec[i][31:0], vec[i][33:32], 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    n_tests++;
    if ({nan_cnt, inf_cnt, nul_cnt} !== {exp_stat(CNT_W'(1)), exp_stat(CNT_W'(1)),
                                         exp_stat(CNT_W'(1))}) begin
      n_fail++;
      $display("FAIL stats_counts: got nan=%0d inf=%0d nul=%0d want %0d each",
               nan_cnt, inf_cnt, nul_cnt, exp_stat(CNT_W'(1)));
    end
    drive(1'b0, 32'd0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({bus.out_vld, bus.out_state, bus.out_result} !== {1'b1, vec[i]}) begin
        n_fail++;
        $display("FAIL stats_data_%0d: got %h want %h",
                 i, {bus.out_state, bus.out_result}, vec[i]);
      end
      tick();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b1, $urandom, 2'($urandom), 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    n_tests++;
    if ({count, overflow} !== {CW'(5), 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_setup: got count=%0d ovf=%b want 5 1", count, overflow);
    end
    rst = 1'b0;
    drive(1'b1, 32'h12345678, 2'b01, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    n_tests++;
    if ({count, empty, bus.out_vld, bus.out_result, overflow} !== {CW'(0), 1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_status: got count=%0d empty=%b vld=%b res=%h ovf=%b want 0 1 0 0 0",
               count, empty, bus.out_vld, bus.out_result, overflow);
    end
    n_tests++;
    if ({drop_cnt, nan_cnt, inf_cnt, nul_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midreset_counters: got drop=%0d nan=%0d inf=%0d nul=%0d want 0",
               drop_cnt, nan_cnt, inf_cnt, nul_cnt);
    end
  endtask

  task automatic test_random();
    logic [33:0] prev_head = '0;
    bit          prev_stall = 1'b0;
    logic        vld;
    logic        rdy;
    int          rdy_pct;
    for (int c = 0; c < 10000; c++) begin
      case (c / 2500)
        0:       rdy_pct = 20;
        1:       rdy_pct = 50;
        2:       rdy_pct = 90;
        default: rdy_pct = 60;
      endcase
      vld = ($urandom_range(99) < 70);
      rdy = ($urandom_range(99) < rdy_pct);
      drive(vld, $urandom, 2'($urandom), rdy);
      #1;
      n_tests++;
      if (bus.out_vld !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL random_vld_c%0d: got %b want %b", c, bus.out_vld, (q.size() != 0));
      end else if (q.size() != 0) begin
        n_tests++;
        if ({bus.out_state, bus.out_result} !== q[0]) begin
          n_fail++;
          $display("FAIL random_head_c%0d: got %h want %h",
                   c, {bus.out_state, bus.out_result}, q[0]);
        end
      end
      if (prev_stall) begin
        n_tests++;
        if ({bus.out_vld, bus.out_state, bus.out_result} !== {1'b1, prev_head}) begin
          n_fail++;
          $display("FAIL random_stable_c%0d: got %h want %h",
                   c, {bus.out_state, bus.out_result}, prev_head);
        end
      end
      prev_stall = bus.out_vld && !rdy;
      prev_head  = {bus.out_state, bus.out_result};
      tick();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    n_tests++;
    if ({drop_cnt, overflow, count} !== {m_drop, m_ovf, CW'(q.size())}) begin
      n_fail++;
      $display("FAIL random_final: got drop=%0d ovf=%b count=%0d want %0d %b %0d",
               drop_cnt, overflow, count, m_drop, m_ovf, q.size());
    end
    n_tests++;
    if ({nan_cnt, inf_cnt, nul_cnt} !== {exp_stat(m_nan), exp_stat(m_inf), exp_stat(m_nul)}) begin
      n_fail++;
      $display("FAIL random_stats: got %0d %0d %0d want %0d %0d %0d", nan_cnt, inf_cnt,
               nul_cnt, exp_stat(m_nan), exp_stat(m_inf), exp_stat(m_nul));
    end
  endtask

  initial begin
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    test_reset();
    test_first_push();
    test_overflow();
    test_full_passthrough();
    test_stats();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_result_buffer.md
# fp_result_buffer

Elastic output stage directly downstream of the pipelined floating-point adder. The adder has no backpressure: it emits one `{result, state}` pair per cycle whenever `res_vld` is high. This block captures every pair into a show-ahead FIFO and presents it to the consumer over a valid/ready handshake. It also tracks results dropped on overflow and, optionally, counts exceptional results.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of all saturating counters

Ports:
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: synchronous, active-low reset
- `in_result` input 32: IEEE-754 single from adder `result`
- `in_state` input 2: adder status code; 00 OK, 01 NAN, 10 INF, 11 NUL
- `in_vld` input 1: adder `res_vld`; a pair is offered this cycle
- `out_result` output 32: head entry result
- `out_state` output 2: head entry status
- `out_vld` output 1: head entry valid
- `out_rdy` input 1: consumer accepts head this cycle
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH
- `full` output 1: `count == DEPTH`
- `empty` output 1: `count == 0`
- `overflow` output 1: sticky; set when any pair was dropped
- `drop_cnt` output CNT_W: dropped pairs, saturating
- `nan_cnt`, `inf_cnt`, `nul_cnt` output CNT_W each: accepted pairs per status, saturating

## Operation
- Storage: `DEPTH` × 34-bit array holding `{state, result}`, with `rd_ptr` and `wr_ptr` of `$clog2(DEPTH)` bits each and a separate `count` register. Both pointers wrap modulo `DEPTH`.
- Push condition: `push = in_vld && (!full || pop)`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- Pop condition: `pop = out_vld && out_rdy`. `rd_ptr` increments.
- Count update: `count` += push − pop.
- Full and popping at once: the push is accepted in the same cycle; `count` stays at `DEPTH`.
- Drop condition: `in_vld && full && !pop`. The pair is discarded, `overflow` is set to 1, and `drop_cnt` increments, saturating at all-ones.
- Show-ahead head: `out_vld = !empty`. `out_result`/`out_state` read the array at `rd_ptr` combinationally. Both are forced to 0 while `out_vld` is 0.
- Input status is stored verbatim, including NAN payloads and signed zero; the block never reinterprets `in_result`.
- `out_vld` is never withdrawn without a pop. Head data is stable while `out_vld && !out_rdy`.
- Reset (`rst` == 0 at a clock edge) clears pointers, `count`, `overflow` and all counters. Stored data is don't-care. This applies mid-stream: entries in flight are lost, and a pair offered in the reset cycle is not captured.

## Timing
- Every output is 0 after reset; `empty` is 1.
- Write-to-read latency is 1 cycle: a pair pushed in cycle N is visible on `out_*` in cycle N+1 if the FIFO was empty.
- Sustained throughput is one push and one pop per cycle.
- `count`, `full`, `empty`, `overflow` and all counters are registered. They reflect the cycle-N push, pop or drop at cycle N+1.
- `out_rdy` is allowed to depend combinationally on `out_vld`. `out_vld` does not depend on `out_rdy`.

## Configuration
- Macro: `FP_RESULT_STATS_EN`.
- Defined: `nan_cnt`, `inf_cnt` and `nul_cnt` each increment on every push whose `in_state` is 01, 10 or 11 respectively. Each saturates at all-ones and is cleared by reset.
- Undefined: the counter registers are not built; the three ports are tied to 0.
- `drop_cnt` and `overflow` are present in both builds.

## Test plan
- Reset, then push 0x3F800000/OK: `out_vld` = 0 in the push cycle and 1 with 0x3F800000/00 the next cycle; `count` = 1.
- Hold `out_rdy` = 0 and push 10 pairs with `DEPTH` = 8: `full` = 1 after 8 pushes; `drop_cnt` = 2 and `overflow` = 1; draining returns the first 8 values in order.
- While full, assert `in_vld` and `out_rdy` for 5 cycles: no drops, `count` stays 8, and the output order is preserved across pointer wrap-around.
- Push 0x7FC00000/NAN, 0x7F800000/INF, 0x80000000/NUL, 0x40000000/OK: with `FP_RESULT_STATS_EN`, the NAN, INF and NUL counters each read 1 and data is unchanged; without it, all three read 0.
- Fill to 5 entries, then pulse `rst` low for 1 cycle while `in_vld` = 1: the next cycle shows `count` = 0, `empty` = 1, `out_vld` = 0, all counters 0 and `overflow` = 0.
- Random `in_vld`/`out_rdy` for 10k cycles against a scoreboard: the sequence out equals the sequence in minus the dropped pairs; `drop_cnt` matches the model, and the head holds stable whenever `out_vld && !out_rdy`.
